barrier_scheduler: RTL and testbench
====================================

Name: barrier_scheduler

Overview:
- Upstream stage of the barrier generator; produces its 2-bit `active` lane select once per game frame.
- Paces barrier spawns with a frame-counted gap.
- Picks the lane pseudo-randomly with a 16-bit LFSR.
- Holds each barrier for its full travel time, then forces a blank interval so the generator's collision latch clears.
- Difficulty ramps by shrinking the gap as barriers are cleared.

Parameters:
- TRAVEL_FRAMES, 120, frames a barrier stays active (lane held non-zero).
- CLEAR_FRAMES, 2, frames `o_active` is forced to 00 after each barrier (min 1).
- GAP_INIT, 90, initial frames between barriers.
- GAP_MIN, 20, floor for the gap.
- GAP_STEP, 10, gap reduction per level.
- LEVEL_LEN, 8, barriers completed per level increment.
- LFSR_SEED, 16'hACE1, LFSR reset value; must be non-zero.

Ports:
- i_clk  in  1  system/pixel clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_v_sync  in  1  raw vertical sync, asynchronous to logic; frame marker.
- i_game_run  in  1  level; 1 = game in progress.
- i_penguin_hit  in  1  collision flag from barrier generator.
- o_active  out  2  00 none, 01 left, 10 mid, 11 right.
- o_level  out  4  current difficulty level, saturates at 15.
- o_barrier_cnt  out  16  barriers completed since run start, wraps.
- o_spawn  out  1  one-cycle pulse when a barrier is issued.

Behaviour:
- Reset (async, i_rst_n=0):
  - o_active=00, o_level=0, o_barrier_cnt=0, o_spawn=0.
  - State IDLE; LFSR=LFSR_SEED; gap=GAP_INIT; frame counter=0.
- Frame tick:
  - i_v_sync passes through a 2-FF synchroniser.
  - frame_tick = one-cycle pulse on the synchronised rising edge.
  - All frame counting advances only on frame_tick.
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11. Steps every frame_tick in any state except IDLE.
- Lane map from lfsr[1:0]: 01→01, 10→10, 11→11, 00→10 (mid).
- FSM states: IDLE, GAP, SPAWN, CLEAR.
  - IDLE: o_active=00. On i_game_run=1 → GAP with frame counter=0.
  - GAP: o_active=00. Count frame_ticks. When count reaches gap-1 on a tick → SPAWN.
    - The SPAWN transition latches the lane, pulses o_spawn for 1 cycle, and resets the counter.
  - SPAWN: o_active=latched lane, constant for the whole state.
    - Exits to CLEAR after TRAVEL_FRAMES ticks, or one cycle after a rising edge of i_penguin_hit, whichever is first.
    - o_barrier_cnt increments on exit, whether hit or not.
  - CLEAR: o_active=00 for CLEAR_FRAMES ticks, then → GAP.
    - On level rollover: o_level+1 (sat 15); gap = max(gap-GAP_STEP, GAP_MIN), with no unsigned underflow.
- Level rollover: barriers completed mod LEVEL_LEN == 0, checked at the SPAWN→CLEAR exit.
- i_game_run=0 in any state: next cycle → IDLE.
  - o_active=00.
  - o_level, o_barrier_cnt and gap reset to initial values. LFSR is not reset.
- o_active changes only on a cycle where frame_tick=1, or on the game_run / hit aborts. It is therefore stable across a displayed frame.
- Simultaneous events:
  - i_game_run=0 beats the hit abort.
  - A hit edge coinciding with the TRAVEL_FRAMES expiry gives a single exit and a single count.
  - frame_tick on the hit-exit cycle is ignored by CLEAR.
- i_penguin_hit high on entry to SPAWN (still latched from a prior barrier) is not an edge; no abort.
- Counters are wide enough for TRAVEL_FRAMES and GAP_INIT; 8 bits suffices for the defaults, sized by $clog2.

Optional Feature:
- Macro BARRIER_NO_REPEAT_EN.
- Defined: if the mapped lane equals the previous spawned lane, rotate it (01→10→11→01) so no lane repeats back-to-back. The previous lane clears to 00 on reset/IDLE.
- Undefined: the mapped lane is used directly; repeats are allowed.

Decomposition:
- Shared package barrier_pkg holds:
  - typedef enum lane_t {LANE_NONE=2'b00, LANE_LEFT=2'b01, LANE_MID=2'b10, LANE_RIGHT=2'b11}.
  - typedef enum sched_state_t.
  - The LFSR tap constant.
- One sub-module: frame_tick_gen (2-FF synchroniser + rising-edge pulse). It is reusable by other per-frame blocks.

Test Plan:
- Reset/idle: assert i_rst_n=0 mid-SPAWN → o_active=00, o_level=0, o_barrier_cnt=0 immediately (async). Release with i_game_run=0 → stays IDLE.
- Basic pacing (GAP_INIT=4, TRAVEL_FRAMES=6, CLEAR_FRAMES=2): raise i_game_run, then issue frame ticks:
  - o_spawn pulses on the 4th tick.
  - o_active is non-zero for exactly 6 ticks, then 00 for 2 ticks, then the next gap starts.
  - o_barrier_cnt=1.
- Hit abort: pulse i_penguin_hit at tick 3 of SPAWN → o_active=00 the next cycle, o_barrier_cnt increments once. Holding i_penguin_hit high into the next SPAWN does not abort it.
- Difficulty (LEVEL_LEN=2, GAP_STEP=10, GAP_INIT=25, GAP_MIN=8):
  - After 2 barriers o_level=1 and gap=15.
  - After 4 barriers o_level=2 and gap=8 (clamped), staying 8 thereafter.
- Lane coverage: run 300 barriers from LFSR_SEED → every o_active value during SPAWN is in {01,10,11}, each lane seen ≥50 times, 00 never seen in SPAWN. With BARRIER_NO_REPEAT_EN, no two consecutive spawns share a lane.
- Game stop: drop i_game_run during SPAWN → o_active=00 the next cycle, counters cleared. Re-raise → the first spawn comes GAP_INIT ticks later.

Source files
------------

// File: rtl/barrier_pkg.sv
// Shared types and helpers for the barrier scheduling path.
//   lane_t        : 2-bit lane select driven to the barrier generator.
//   sched_state_t : scheduler FSM states.
//   LFSR_TAPS     : Galois tap mask for x^16+x^14+x^13+x^11 (right-shifting form).
package barrier_pkg;

  typedef enum logic [1:0] {
    LANE_NONE  = 2'b00,
    LANE_LEFT  = 2'b01,
    LANE_MID   = 2'b10,
    LANE_RIGHT = 2'b11
  } lane_t;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StGap   = 2'b01,
    StSpawn = 2'b10,
    StClear = 2'b11
  } sched_state_t;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_step(input logic [15:0] state);
    return state[0] ? ((state >> 1) ^ LFSR_TAPS) : (state >> 1);
  endfunction

  // 00 has no lane of its own; fold it onto the middle lane.
  function automatic lane_t lane_map(input logic [1:0] bits);
    unique case (bits)
      2'b01:   return LANE_LEFT;
      2'b11:   return LANE_RIGHT;
      default: return LANE_MID;
    endcase
  endfunction

  function automatic lane_t lane_rotate(input lane_t lane);
    unique case (lane)
      LANE_LEFT:  return LANE_MID;
      LANE_MID:   return LANE_RIGHT;
      LANE_RIGHT: return LANE_LEFT;
      default:    return LANE_NONE;
    endcase
  endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Turns a raw, asynchronous vertical-sync input into a one-cycle frame tick.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_v_sync       : raw vertical sync (asynchronous)
//   o_frame_tick   : one-cycle pulse on the synchronised rising edge
module frame_tick_gen (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_v_sync,
  output logic o_frame_tick
);

  logic sync1_q, sync2_q, prev_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= i_v_sync;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign o_frame_tick = sync2_q & ~prev_q;

endmodule

// File: rtl/barrier_scheduler.sv
// Paces barrier spawns for the barrier generator, one decision per frame.
// Build option: define BARRIER_NO_REPEAT_EN to forbid the same lane twice in a row.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_v_sync       : raw vertical sync, frame marker
//   i_game_run     : 1 while a game is in progress; 0 aborts to idle
//   i_penguin_hit  : collision flag; its rising edge ends the current barrier
//   o_active       : lane select (00 none, 01 left, 10 mid, 11 right)
//   o_level        : difficulty level, saturating at 15
//   o_barrier_cnt  : barriers completed since run start (wraps)
//   o_spawn        : one-cycle pulse when a barrier is issued
module barrier_scheduler
  import barrier_pkg::*;
#(
  parameter int unsigned TRAVEL_FRAMES = 120,
  parameter int unsigned CLEAR_FRAMES  = 2,
  parameter int unsigned GAP_INIT      = 90,
  parameter int unsigned GAP_MIN       = 20,
  parameter int unsigned GAP_STEP      = 10,
  parameter int unsigned LEVEL_LEN     = 8,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_v_sync,
  input  logic        i_game_run,
  input  logic        i_penguin_hit,
  output logic [1:0]  o_active,
  output logic [3:0]  o_level,
  output logic [15:0] o_barrier_cnt,
  output logic        o_spawn
);

  localparam int unsigned CntMax0 = (TRAVEL_FRAMES > GAP_INIT) ? TRAVEL_FRAMES : GAP_INIT;
  localparam int unsigned CntMax  = (CntMax0 > CLEAR_FRAMES) ? CntMax0 : CLEAR_FRAMES;
  localparam int unsigned CntW    = $clog2(CntMax + 1);
  localparam int unsigned LvlW    = (LEVEL_LEN > 1) ? $clog2(LEVEL_LEN) : 1;

  logic frame_tick;

  frame_tick_gen u_frame_tick_gen (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_v_sync     (i_v_sync),
    .o_frame_tick (frame_tick)
  );

  sched_state_t    state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [CntW-1:0] gap_q, gap_d;
  logic [15:0]     lfsr_q, lfsr_d;
  lane_t           lane_q, lane_d;
  logic [3:0]      level_q, level_d;
  logic [15:0]     bcnt_q, bcnt_d;
  logic [LvlW-1:0] lvl_cnt_q, lvl_cnt_d;
  logic            spawn_q, spawn_d;
  logic            hit_q;
  logic            hit_edge;
  lane_t           lane_pick;

  assign hit_edge = i_penguin_hit & ~hit_q;

  // lane_q still holds the previously spawned lane while in GAP.
  always_comb begin
    lane_pick = lane_map(lfsr_q[1:0]);
`ifdef BARRIER_NO_REPEAT_EN
    if (lane_pick == lane_q) lane_pick = lane_rotate(lane_pick);
`endif
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    gap_d     = gap_q;
    lfsr_d    = lfsr_q;
    lane_d    = lane_q;
    level_d   = level_q;
    bcnt_d    = bcnt_q;
    lvl_cnt_d = lvl_cnt_q;
    spawn_d   = 1'b0;

    if (frame_tick && (state_q != StIdle)) lfsr_d = lfsr_step(lfsr_q);

    if (!i_game_run) begin
      state_d   = StIdle;
      cnt_d     = '0;
      gap_d     = CntW'(GAP_INIT);
      lane_d    = LANE_NONE;
      level_d   = '0;
      bcnt_d    = '0;
      lvl_cnt_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StGap;
          cnt_d   = '0;
        end
        StGap: begin
          if (frame_tick) begin
            if (cnt_q == gap_q - CntW'(1)) begin
              state_d = StSpawn;
              cnt_d   = '0;
              lane_d  = lane_pick;
              spawn_d = 1'b1;
            end else begin
              cnt_d = cnt_q + CntW'(1);
            end
          end
        end
        StSpawn: begin
          // A hit edge and travel expiry on the same cycle merge into one exit.
          if (hit_edge || (frame_tick && (cnt_q == CntW'(TRAVEL_FRAMES - 1)))) begin
            state_d = StClear;
            cnt_d   = '0;
            bcnt_d  = bcnt_q + 16'd1;
            if (lvl_cnt_q == LvlW'(LEVEL_LEN - 1)) begin
              lvl_cnt_d = '0;
              if (level_q != 4'd15) level_d = level_q + 4'd1;
              if (32'(gap_q) >= GAP_MIN + GAP_STEP) gap_d = gap_q - CntW'(GAP_STEP);
              else                                  gap_d = CntW'(GAP_MIN);
            end else begin
              lvl_cnt_d = lvl_cnt_q + LvlW'(1);
            end
          end else if (frame_tick) begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StClear: begin
          if (frame_tick) begin
            if (cnt_q == CntW'(CLEAR_FRAMES - 1)) begin
              state_d = StGap;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CntW'(1);
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      gap_q     <= CntW'(GAP_INIT);
      lfsr_q    <= LFSR_SEED;
      lane_q    <= LANE_NONE;
      level_q   <= '0;
      bcnt_q    <= '0;
      lvl_cnt_q <= '0;
      spawn_q   <= 1'b0;
      hit_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      gap_q     <= gap_d;
      lfsr_q    <= lfsr_d;
      lane_q    <= lane_d;
      level_q   <= level_d;
      bcnt_q    <= bcnt_d;
      lvl_cnt_q <= lvl_cnt_d;
      spawn_q   <= spawn_d;
      hit_q     <= i_penguin_hit;
    end
  end

  assign o_active      = (state_q == StSpawn) ? lane_q : LANE_NONE;
  assign o_level       = level_q;
  assign o_barrier_cnt = bcnt_q;
  assign o_spawn       = spawn_q;

endmodule

// File: tb/tb_barrier_scheduler.sv
module tb_barrier_scheduler;

  localparam int Travel  = 6;
  localparam int ClearF  = 2;
  localparam int GapInit = 12;
  localparam int GapMin  = 4;
  localparam int GapStep = 3;
  localparam int LvlLen  = 2;
  localparam int Seed    = 'hACE1;

  localparam int PIdle  = 0;  // no game
  localparam int PWait  = 1;  // waiting out the gap
  localparam int POn    = 2;  // barrier on screen
  localparam int PBlank = 3;  // forced blank after a barrier

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        v_sync = 1'b0;
  logic        game_run = 1'b0;
  logic        hit = 1'b0;
  logic [1:0]  active;
  logic [3:0]  level;
  logic [15:0] bcnt;
  logic        spawn;

  always #5 clk = ~clk;

  barrier_scheduler #(
    .TRAVEL_FRAMES (Travel),
    .CLEAR_FRAMES  (ClearF),
    .GAP_INIT      (GapInit),
    .GAP_MIN       (GapMin),
    .GAP_STEP      (GapStep),
    .LEVEL_LEN     (LvlLen),
    .LFSR_SEED     (16'hACE1)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_v_sync      (v_sync),
    .i_game_run    (game_run),
    .i_penguin_hit (hit),
    .o_active      (active),
    .o_level       (level),
    .o_barrier_cnt (bcnt),
    .o_spawn       (spawn)
  );

  typedef struct packed {
    logic [1:0]  act;
    logic [3:0]  lvl;
    logic [15:0] cnt;
  } obs_t;

  obs_t frame_q[$];
  obs_t spawn_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   lane_seen[4];
  int   total_spawns = 0;
  int   repeats = 0;
  int   last_lane = 0;

  // Reference model, frame granularity.
  int m_phase, m_frames, m_gap, m_level, m_count, m_lane, m_lfsr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic obs_t mk_obs(input int a, input int l, input int c);
    obs_t o;
    o.act = 2'(a);
    o.lvl = 4'(l);
    o.cnt = 16'(c);
    return o;
  endfunction

  function automatic int lfsr_next(input int s);
    if ((s & 1) != 0) return (s >> 1) ^ 'hB400;
    return s >> 1;
  endfunction

  function automatic int lane_of(input int s);
    case (s & 3)
      1:       return 1;
      3:       return 3;
      default: return 2;
    endcase
  endfunction

  task automatic model_reset_game();
    m_gap    = GapInit;
    m_level  = 0;
    m_count  = 0;
    m_lane   = 0;
    m_frames = 0;
  endtask

  task automatic model_end_barrier();
    m_count = (m_count + 1) % 65536;
    if (m_count % LvlLen == 0) begin
      if (m_level < 15) m_level++;
      m_gap = (m_gap - GapStep < GapMin) ? GapMin : m_gap - GapStep;
    end
    m_phase  = PBlank;
    m_frames = 0;
  endtask

  task automatic model_tick();
    int prev, lane;
    if (m_phase == PIdle) return;
    prev   = m_lfsr;
    m_lfsr = lfsr_next(m_lfsr);
    m_frames++;
    case (m_phase)
      PWait: if (m_frames == m_gap) begin
        lane = lane_of(prev);
`ifdef BARRIER_NO_REPEAT_EN
        if (lane == m_lane) lane = lane % 3 + 1;
`endif
        m_lane = lane;
        spawn_q.push_back(mk_obs(lane, m_level, m_count));
        m_phase  = POn;
        m_frames = 0;
      end
      POn: if (m_frames == Travel) model_end_barrier();
      PBlank: if (m_frames == ClearF) begin
        m_phase  = PWait;
        m_frames = 0;
      end
      default: ;
    endcase
  endtask

  task automatic frame();
    frame_q.push_back(mk_obs((m_phase == POn) ? m_lane : 0, m_level, m_count));
    @(posedge clk);
    #1 v_sync = 1'b1;
    model_tick();
    repeat (4) @(posedge clk);
    #1 v_sync = 1'b0;
    repeat ($urandom_range(4, 8)) @(posedge clk);
  endtask

  task automatic set_hit(input logic v);
    @(posedge clk);
    #1;
    if (v && !hit && m_phase == POn) model_end_barrier();
    hit = v;
    repeat (2) @(posedge clk);
  endtask

  task automatic set_run(input logic v);
    @(posedge clk);
    #1 game_run = v;
    if (!v) begin
      m_phase = PIdle;
      model_reset_game();
    end else if (m_phase == PIdle) begin
      m_phase  = PWait;
      m_frames = 0;
    end
    repeat (2) @(posedge clk);
  endtask

  // Monitor: per-frame state at each v_sync rise, and every spawn pulse.
  logic v_prev = 1'b0;
  always @(negedge clk) begin
    obs_t e;
    v_prev <= v_sync;
    if (rst_n && v_sync && !v_prev) begin
      if (frame_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL frame_queue: got frame with empty expectation queue");
      end else begin
        e = frame_q.pop_front();
        check("frame_active", 32'(active), 32'(e.act));
        check("frame_level", 32'(level), 32'(e.lvl));
        check("frame_count", 32'(bcnt), 32'(e.cnt));
      end
    end
    if (rst_n && spawn) begin
      total_spawns++;
      lane_seen[active]++;
      if (32'(active) == last_lane) repeats++;
      last_lane = 32'(active);
      if (spawn_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL spawn_queue: got spawn lane %0d, expected no spawn", active);
      end else begin
        e = spawn_q.pop_front();
        check("spawn_lane", 32'(active), 32'(e.act));
        check("spawn_level", 32'(level), 32'(e.lvl));
        check("spawn_count", 32'(bcnt), 32'(e.cnt));
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, s0;
    for (int i = 0; i < 4; i++) lane_seen[i] = 0;
    m_lfsr  = Seed;
    m_phase = PIdle;
    model_reset_game();

    repeat (3) @(posedge clk);
    #1;
    check("reset_active", 32'(active), 0);
    check("reset_level", 32'(level), 0);
    check("reset_count", 32'(bcnt), 0);
    check("reset_spawn", 32'(spawn), 0);
    rst_n = 1'b1;
    frame();
    frame();

    // Basic pacing: first spawn on the GapInit-th tick.
    set_run(1'b1);
    n  = 0;
    s0 = total_spawns;
    while (total_spawns == s0 && n < 50) begin
      frame();
      n++;
    end
    check("first_spawn_tick", n, GapInit);

    // Hit abort at tick 3 of the barrier; hold the hit into the next barrier.
    repeat (3) frame();
    set_hit(1'b1);
    check("hit_abort_active", 32'(active), 0);
    check("hit_abort_count", 32'(bcnt), 1);
    repeat (ClearF + GapInit + Travel + 2) frame();
    set_hit(1'b0);

    // Asynchronous reset in the middle of a barrier.
    n = 0;
    while (m_phase != POn && n < 100) begin
      frame();
      n++;
    end
    check("reached_spawn_before_reset", m_phase, POn);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async_reset_active", 32'(active), 0);
    check("async_reset_level", 32'(level), 0);
    check("async_reset_count", 32'(bcnt), 0);
    game_run = 1'b0;
    m_phase  = PIdle;
    m_lfsr   = Seed;
    model_reset_game();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) frame();

    // Game stop during a barrier, then restart.
    set_run(1'b1);
    n = 0;
    while (m_phase != POn && n < 100) begin
      frame();
      n++;
    end
    @(posedge clk);
    #1 game_run = 1'b0;
    m_phase = PIdle;
    model_reset_game();
    @(posedge clk);
    #1;
    check("stop_active", 32'(active), 0);
    check("stop_level", 32'(level), 0);
    check("stop_count", 32'(bcnt), 0);
    set_run(1'b1);
    n  = 0;
    s0 = total_spawns;
    while (total_spawns == s0 && n < 50) begin
      frame();
      n++;
    end
    check("restart_spawn_tick", n, GapInit);

    // Long randomized run with random hit edges.
    n = 0;
    while (total_spawns < 300 && n < 8000) begin
      frame();
      n++;
      if (!hit && m_phase == POn && $urandom_range(0, 5) == 0) set_hit(1'b1);
      else if (hit && $urandom_range(0, 3) == 0) set_hit(1'b0);
    end
    check("spawn_budget_reached", 32'(total_spawns >= 300), 1);
    repeat (20) @(posedge clk);
    check("spawn_queue_drained", spawn_q.size(), 0);
    check("frame_queue_drained", frame_q.size(), 0);
    check("lane_none_in_spawn", lane_seen[0], 0);
    for (int i = 1; i < 4; i++) check("lane_coverage", 32'(lane_seen[i] >= 50), 1);
`ifdef BARRIER_NO_REPEAT_EN
    check("no_repeat_lanes", repeats, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
